pong_game_ctrl: RTL and testbench

- Per-frame game controller for the VGA pong renderer: owns ball position, paddle positions, serve timing, wall/paddle bounces and scoring.
- Drives the renderer's bola_x, bola_y, barra_e_y and barra_d_y inputs.
- Advances exactly once per video frame, on the rising edge of the renderer's VSync.
- Geometry: 640x480 screen, 6-row top and bottom walls, left paddle at x 0..14, right paddle at x 630..639, 20x20 ball.

---
 rtl/pong_game_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Per-frame pong game controller: ball, paddles, serve timing, bounces and scoring.
// All game state advances once per frame on the rising edge of the renderer's VSync.
module pong_game_ctrl #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int WALL_H       = 6,
   parameter int PAD_W        = 15,
   parameter int PAD_H        = 80,
   parameter int PAD_D_X      = 630,
   parameter int BALL_SZ      = 20,
   parameter int PAD_STEP     = 4,
   parameter int BALL_STEP    = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       VSync,
   input  logic       btn_e_up,
   input  logic       btn_e_dn,
   input  logic       btn_d_up,
   input  logic       btn_d_dn,
   input  logic       start,
   output logic [9:0] bola_x,
   output logic [9:0] bola_y,
   output logic [9:0] barra_e_y,
   output logic [9:0] barra_d_y,
   output logic [3:0] score_e,
   output logic [3:0] score_d,
   output logic       point,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_SCORE = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic [10:0] WALL       = 11'(WALL_H);
   localparam logic [10:0] PSTEP      = 11'(PAD_STEP);
   localparam logic [10:0] BSTEP      = 11'(BALL_STEP);
   localparam logic [10:0] BSZ        = 11'(BALL_SZ);
   localparam logic [10:0] PH         = 11'(PAD_H);
   localparam logic [10:0] PW         = 11'(PAD_W);
   localparam logic [10:0] PDX        = 11'(PAD_D_X);
   localparam logic [10:0] Y_PAD_MAX  = 11'(SCREEN_H - WALL_H - PAD_H);
   localparam logic [10:0] Y_BALL_MAX = 11'(SCREEN_H - WALL_H - BALL_SZ);
   localparam logic [9:0]  X_CTR      = 10'((SCREEN_W - BALL_SZ) / 2);
   localparam logic [9:0]  Y_CTR      = 10'((SCREEN_H - BALL_SZ) / 2);
   localparam logic [9:0]  PAD_CTR    = 10'((SCREEN_H - PAD_H) / 2);
   localparam logic [9:0]  X_BOUNCE_E = 10'(PAD_W);
   localparam logic [9:0]  X_BOUNCE_D = 10'(PAD_D_X - BALL_SZ);
   localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

   logic       vs_q_r;
   logic       tick_s;
   state_t     state_r, state_nxt_s;
   logic [7:0] cnt_r, cnt_nxt_s;
   logic [9:0] ball_x_r, ball_x_nxt_s, ball_y_r, ball_y_nxt_s;
   logic [9:0] pad_e_r, pad_e_nxt_s, pad_d_r, pad_d_nxt_s;
   logic [3:0] score_e_r, score_e_nxt_s, score_d_r, score_d_nxt_s;
   logic       point_r, point_nxt_s;
   logic       dx_r, dx_nxt_s, dy_r, dy_nxt_s;
   logic [10:0] bx_w_s, by_w_s, pe_w_s, pd_w_s;
   logic       hit_e_s, hit_d_s;

   // Paddle step with wall clamping; 11-bit math keeps the subtraction from wrapping
   function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
      logic [10:0] y_w;
      logic [9:0]  res;
      y_w = {1'b0, y};
      if (up && !dn) begin
         if (y_w <= WALL + PSTEP) res = 10'(WALL);
         else                     res = 10'(y_w - PSTEP);
      end else if (dn && !up) begin
         if (y_w + PSTEP >= Y_PAD_MAX) res = 10'(Y_PAD_MAX);
         else                          res = 10'(y_w + PSTEP);
      end else begin
         res = y;
      end
      return res;
   endfunction

   assign tick_s  = VSync & ~vs_q_r;
   assign bx_w_s  = {1'b0, ball_x_r};
   assign by_w_s  = {1'b0, ball_y_r};
   assign pe_w_s  = {1'b0, pad_e_r};
   assign pd_w_s  = {1'b0, pad_d_r};
   // Overlap uses the paddle positions from before this frame's move
   assign hit_e_s = (by_w_s + BSZ > pe_w_s) && (by_w_s < pe_w_s + PH);
   assign hit_d_s = (by_w_s + BSZ > pd_w_s) && (by_w_s < pd_w_s + PH);

   // Next-state and next-value logic for the game FSM
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      ball_x_nxt_s  = ball_x_r;
      ball_y_nxt_s  = ball_y_r;
      score_e_nxt_s = score_e_r;
      score_d_nxt_s = score_d_r;
      dx_nxt_s      = dx_r;
      dy_nxt_s      = dy_r;
      point_nxt_s   = 1'b0;
      if (tick_s) begin
         pad_e_nxt_s = paddle_next(pad_e_r, btn_e_up, btn_e_dn);
         pad_d_nxt_s = paddle_next(pad_d_r, btn_d_up, btn_d_dn);
      end else begin
         pad_e_nxt_s = pad_e_r;
         pad_d_nxt_s = pad_d_r;
      end
      case (state_r)
         ST_SERVE: begin
            ball_x_nxt_s = X_CTR;
            ball_y_nxt_s = Y_CTR;
            if (tick_s && cnt_r == SERVE_LAST) begin
               cnt_nxt_s   = 8'd0;
               state_nxt_s = ST_PLAY;
            end else if (tick_s) begin
               cnt_nxt_s = cnt_r + 8'd1;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_PLAY: begin
            if (tick_s) begin
               if (dy_r) begin
                  if (by_w_s + BSTEP >= Y_BALL_MAX) begin
                     ball_y_nxt_s = 10'(Y_BALL_MAX);
                     dy_nxt_s     = 1'b0;
                  end else begin
                     ball_y_nxt_s = 10'(by_w_s + BSTEP);
                  end
               end else begin
                  if (by_w_s <= WALL + BSTEP) begin
                     ball_y_nxt_s = 10'(WALL);
                     dy_nxt_s     = 1'b1;
                  end else begin
                     ball_y_nxt_s = 10'(by_w_s - BSTEP);
                  end
               end
               // A miss leaves x where it was; the ball is recentred on the SCORE tick
               if (!dx_r) begin
                  if (bx_w_s <= PW + BSTEP && hit_e_s) begin
                     ball_x_nxt_s = X_BOUNCE_E;
                     dx_nxt_s     = 1'b1;
                  end else if (bx_w_s <= PW + BSTEP) begin
                     score_d_nxt_s = (score_d_r < WIN) ? score_d_r + 4'd1 : score_d_r;
                     point_nxt_s   = 1'b1;
                     dx_nxt_s      = 1'b0;
                     state_nxt_s   = ST_SCORE;
                  end else begin
                     ball_x_nxt_s = 10'(bx_w_s - BSTEP);
                  end
               end else begin
                  if (bx_w_s + BSTEP + BSZ >= PDX && hit_d_s) begin
                     ball_x_nxt_s = X_BOUNCE_D;
                     dx_nxt_s     = 1'b0;
                  end else if (bx_w_s + BSTEP + BSZ >= PDX) begin
                     score_e_nxt_s = (score_e_r < WIN) ? score_e_r + 4'd1 : score_e_r;
                     point_nxt_s   = 1'b1;
                     dx_nxt_s      = 1'b1;
                     state_nxt_s   = ST_SCORE;
                  end else begin
                     ball_x_nxt_s = 10'(bx_w_s + BSTEP);
                  end
               end
            end else begin
               ball_x_nxt_s = ball_x_r;
               ball_y_nxt_s = ball_y_r;
            end
         end
         ST_SCORE: begin
            if (tick_s) begin
               ball_x_nxt_s = X_CTR;
               ball_y_nxt_s = Y_CTR;
               dy_nxt_s     = 1'b1;
               if (score_e_r == WIN || score_d_r == WIN) begin
                  state_nxt_s = ST_OVER;
               end else begin
                  state_nxt_s = ST_SERVE;
                  cnt_nxt_s   = 8'd0;
               end
            end else begin
               state_nxt_s = ST_SCORE;
            end
         end
         ST_OVER: begin
            ball_x_nxt_s = X_CTR;
            ball_y_nxt_s = Y_CTR;
            if (start) begin
               score_e_nxt_s = 4'd0;
               score_d_nxt_s = 4'd0;
               cnt_nxt_s     = 8'd0;
               state_nxt_s   = ST_SERVE;
            end else begin
               state_nxt_s = ST_OVER;
            end
         end
         default: begin
            state_nxt_s = ST_SERVE;
         end
      endcase
   end

   // Game state registers with asynchronous reset
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_q_r    <= 1'b0;
         state_r   <= ST_SERVE;
         cnt_r     <= 8'd0;
         ball_x_r  <= X_CTR;
         ball_y_r  <= Y_CTR;
         pad_e_r   <= PAD_CTR;
         pad_d_r   <= PAD_CTR;
         score_e_r <= 4'd0;
         score_d_r <= 4'd0;
         point_r   <= 1'b0;
         dx_r      <= 1'b1;
         dy_r      <= 1'b1;
      end else begin
         vs_q_r    <= VSync;
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         ball_x_r  <= ball_x_nxt_s;
         ball_y_r  <= ball_y_nxt_s;
         pad_e_r   <= pad_e_nxt_s;
         pad_d_r   <= pad_d_nxt_s;
         score_e_r <= score_e_nxt_s;
         score_d_r <= score_d_nxt_s;
         point_r   <= point_nxt_s;
         dx_r      <= dx_nxt_s;
         dy_r      <= dy_nxt_s;
      end
   end

   assign bola_x    = ball_x_r;
   assign bola_y    = ball_y_r;
   assign barra_e_y = pad_e_r;
   assign barra_d_y = pad_d_r;
   assign score_e   = score_e_r;
   assign score_d   = score_d_r;
   assign point     = point_r;
   assign state     = state_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a behavioural game model feeds a scoreboard
// of expected per-frame outputs, and scenario tasks add directed checks.
module tb_pong_game_ctrl;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b1;
   logic       VSync = 1'b0;
   logic       btn_e_up = 1'b0, btn_e_dn = 1'b0, btn_d_up = 1'b0, btn_d_dn = 1'b0;
   logic       start = 1'b0;
   logic [9:0] bola_x, bola_y, barra_e_y, barra_d_y;
   logic [3:0] score_e, score_d;
   logic       point;
   logic [1:0] state;

   pong_game_ctrl dut (
      .Clock(Clock), .Reset_n(Reset_n), .VSync(VSync),
      .btn_e_up(btn_e_up), .btn_e_dn(btn_e_dn), .btn_d_up(btn_d_up), .btn_d_dn(btn_d_dn),
      .start(start), .bola_x(bola_x), .bola_y(bola_y), .barra_e_y(barra_e_y),
      .barra_d_y(barra_d_y), .score_e(score_e), .score_d(score_d), .point(point), .state(state)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int bx; int by; int pe; int pd; int se; int sd; int pt; int st;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_errors = 0;
   int n_frames = 0;

   // behavioural game model
   int m_bx, m_by, m_pe, m_pd, m_se, m_sd, m_pt, m_st, m_cnt, m_dx, m_dy;
   int m_lb = 0;

   function automatic int pad_move(int y, bit up, bit dn);
      if (up && !dn) return (y - 4 < 6) ? 6 : y - 4;
      else if (dn && !up) return (y + 4 > 394) ? 394 : y + 4;
      return y;
   endfunction

   task automatic model_reset();
      m_bx = 310; m_by = 230; m_pe = 200; m_pd = 200;
      m_se = 0; m_sd = 0; m_pt = 0; m_st = 0; m_cnt = 0; m_dx = 1; m_dy = 1;
   endtask

   task automatic model_tick(input bit eu, input bit ed, input bit du, input bit dd, output exp_t e);
      int pe0, pd0, ny;
      pe0 = m_pe; pd0 = m_pd; m_pt = 0;
      m_pe = pad_move(m_pe, eu, ed);
      m_pd = pad_move(m_pd, du, dd);
      case (m_st)
         0: begin
            m_bx = 310; m_by = 230;
            if (m_cnt == 59) begin m_cnt = 0; m_st = 1; end
            else m_cnt = m_cnt + 1;
         end
         1: begin
            if (m_dy == 1) begin
               ny = m_by + 2;
               if (ny >= 454) begin ny = 454; m_dy = 0; end
            end else begin
               if (m_by <= 8) begin ny = 6; m_dy = 1; end
               else ny = m_by - 2;
            end
            if (m_dx == 0) begin
               if (m_bx - 2 <= 15) begin
                  if (m_by + 20 > pe0 && m_by < pe0 + 80) begin m_bx = 15; m_dx = 1; m_lb++; end
                  else begin m_sd++; m_pt = 1; m_dx = 0; m_st = 2; end
               end else m_bx = m_bx - 2;
            end else begin
               if (m_bx + 2 + 20 >= 630) begin
                  if (m_by + 20 > pd0 && m_by < pd0 + 80) begin m_bx = 610; m_dx = 0; end
                  else begin m_se++; m_pt = 1; m_dx = 1; m_st = 2; end
               end else m_bx = m_bx + 2;
            end
            m_by = ny;
         end
         2: begin
            m_bx = 310; m_by = 230; m_dy = 1;
            if (m_se == 9 || m_sd == 9) m_st = 3;
            else begin m_st = 0; m_cnt = 0; end
         end
         default: begin m_bx = 310; m_by = 230; end
      endcase
      e = '{m_bx, m_by, m_pe, m_pd, m_se, m_sd, m_pt, m_st};
   endtask

   // One frame: VSync pulse, then compare 1 Clock after the edge and again later in the frame
   task automatic run_frame(input bit eu, input bit ed, input bit du, input bit dd);
      exp_t e;
      logic bad;
      @(negedge Clock);
      btn_e_up = eu; btn_e_dn = ed; btn_d_up = du; btn_d_dn = dd;
      VSync = 1'b1;
      model_tick(eu, ed, du, dd, e);
      sb.push_back(e);
      n_frames++;
      @(posedge Clock); #1;
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $display("FAIL scoreboard_empty frame%0d", n_frames);
      end else begin
         e = sb.pop_front();
         for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
               @(negedge Clock); VSync = 1'b0;
               @(posedge Clock); #1;
               n_checks++;
            end
            bad = (bola_y !== 10'(e.by)) || (barra_e_y !== 10'(e.pe)) || (barra_d_y !== 10'(e.pd)) ||
                  (score_e !== 4'(e.se)) || (score_d !== 4'(e.sd)) || (state !== 2'(e.st)) ||
                  (point !== ((ph == 0 && e.pt != 0) ? 1'b1 : 1'b0)) ||
                  (e.pt == 0 && bola_x !== 10'(e.bx));
            if (bad) begin
               n_errors++;
               if (n_errors <= 20)
                  $display("FAIL frame%0d_ph%0d got x=%0d y=%0d e=%0d d=%0d se=%0d sd=%0d pt=%0b st=%0d required x=%0d y=%0d e=%0d d=%0d se=%0d sd=%0d pt=%0d st=%0d",
                           n_frames, ph, bola_x, bola_y, barra_e_y, barra_d_y, score_e, score_d, point, state,
                           e.bx, e.by, e.pe, e.pd, e.se, e.sd, (ph == 0) ? e.pt : 0, e.st);
            end
         end
      end
      @(posedge Clock);
   endtask

   // mode 0 tracks the ball, mode 1 moves away from it; returns {up, dn}
   function automatic bit [1:0] ai(int mode, int p);
      int bc, pc;
      bc = m_by + 10; pc = p + 40;
      if (mode == 0) begin
         if (pc < bc - 2) return 2'b01;
         else if (pc > bc + 2) return 2'b10;
         return 2'b00;
      end
      if (bc >= pc) return 2'b10;
      return 2'b01;
   endfunction

   task automatic ai_frame(input int mode_e, input int mode_d);
      bit [1:0] be, bd;
      be = ai(mode_e, m_pe);
      bd = ai(mode_d, m_pd);
      run_frame(be[1], be[0], bd[1], bd[0]);
   endtask

   task automatic test_reset();
      #2 Reset_n = 1'b0;
      #1;
      n_checks++; if (bola_x !== 10'd310) begin n_errors++; $display("FAIL reset_bola_x got %0d required 310", bola_x); end
      n_checks++; if (bola_y !== 10'd230) begin n_errors++; $display("FAIL reset_bola_y got %0d required 230", bola_y); end
      n_checks++; if (barra_e_y !== 10'd200 || barra_d_y !== 10'd200) begin n_errors++; $display("FAIL reset_paddles got %0d/%0d required 200/200", barra_e_y, barra_d_y); end
      n_checks++; if (score_e !== 4'd0 || score_d !== 4'd0 || point !== 1'b0 || state !== 2'd0) begin
         n_errors++; $display("FAIL reset_misc got se=%0d sd=%0d pt=%0b st=%0d required 0 0 0 0", score_e, score_d, point, state); end
      model_reset();
      repeat (3) @(posedge Clock);
      @(negedge Clock) Reset_n = 1'b1;
   endtask

   task automatic test_serve();
      for (int i = 1; i <= 61; i++) begin
         run_frame(1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 59) begin
            n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL serve_hold_59 got st=%0d required 0", state); end
         end
         if (i == 60) begin
            n_checks++; if (state !== 2'd1) begin n_errors++; $display("FAIL serve_to_play_60 got st=%0d required 1", state); end
         end
         if (i == 61) begin
            n_checks++; if (bola_x !== 10'd312 || bola_y !== 10'd232) begin
               n_errors++; $display("FAIL first_move got (%0d,%0d) required (312,232)", bola_x, bola_y); end
         end
      end
   endtask

   task automatic test_paddles();
      repeat (5) run_frame(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (barra_e_y !== 10'd200) begin n_errors++; $display("FAIL both_buttons_hold got %0d required 200", barra_e_y); end
      repeat (60) run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (barra_e_y !== 10'd6) begin n_errors++; $display("FAIL paddle_e_top got %0d required 6", barra_e_y); end
      repeat (60) run_frame(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (barra_d_y !== 10'd394) begin n_errors++; $display("FAIL paddle_d_bottom got %0d required 394", barra_d_y); end
   endtask

   task automatic test_rally();
      int lb0, sd0, n;
      lb0 = m_lb; sd0 = m_sd; n = 0;
      while (m_lb == lb0 && n < 1500) begin ai_frame(0, 0); n++; end
      n_checks++; if (m_lb == lb0) begin n_errors++; $display("FAIL left_bounce_timeout after %0d frames", n); end
      n = 0;
      while (m_sd == sd0 && n < 1500) begin ai_frame(1, 0); n++; end
      n_checks++; if (m_sd == sd0) begin n_errors++; $display("FAIL left_miss_timeout after %0d frames", n); end
      n_checks++; if (state !== 2'd2 || score_d !== 4'd1) begin
         n_errors++; $display("FAIL left_miss_score got st=%0d sd=%0d required 2 1", state, score_d); end
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (state !== 2'd0 || bola_x !== 10'd310 || bola_y !== 10'd230) begin
         n_errors++; $display("FAIL score_to_serve got st=%0d (%0d,%0d) required 0 (310,230)", state, bola_x, bola_y); end
   endtask

   task automatic test_game_over();
      int n;
      n = 0;
      while (m_st != 3 && n < 6000) begin ai_frame(0, 1); n++; end
      n_checks++; if (m_st != 3) begin n_errors++; $display("FAIL game_over_timeout after %0d frames", n); end
      n_checks++; if (state !== 2'd3 || score_e !== 4'd9) begin
         n_errors++; $display("FAIL game_over got st=%0d se=%0d required 3 9", state, score_e); end
      repeat (5) run_frame(1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++; if (bola_x !== 10'd310 || bola_y !== 10'd230 || score_e !== 4'd9) begin
         n_errors++; $display("FAIL game_over_hold got (%0d,%0d) se=%0d required (310,230) 9", bola_x, bola_y, score_e); end
      @(negedge Clock) start = 1'b1;
      if (m_st == 3) begin m_se = 0; m_sd = 0; m_cnt = 0; m_st = 0; end
      @(posedge Clock); #1;
      n_checks++; if (state !== 2'd0 || score_e !== 4'd0 || score_d !== 4'd0) begin
         n_errors++; $display("FAIL start_restart got st=%0d se=%0d sd=%0d required 0 0 0", state, score_e, score_d); end
      @(negedge Clock) start = 1'b0;
   endtask

   task automatic test_reset_mid_play();
      repeat (65) run_frame(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (state !== 2'd1) begin n_errors++; $display("FAIL pre_reset_play got st=%0d required 1", state); end
      @(posedge Clock); #2 Reset_n = 1'b0;
      #1;
      n_checks++; if (bola_x !== 10'd310 || bola_y !== 10'd230 || barra_e_y !== 10'd200 || barra_d_y !== 10'd200) begin
         n_errors++; $display("FAIL async_reset_pos got (%0d,%0d) e=%0d d=%0d required (310,230) 200 200", bola_x, bola_y, barra_e_y, barra_d_y); end
      n_checks++; if (state !== 2'd0 || score_e !== 4'd0 || score_d !== 4'd0 || point !== 1'b0) begin
         n_errors++; $display("FAIL async_reset_misc got st=%0d se=%0d sd=%0d pt=%0b required 0 0 0 0", state, score_e, score_d, point); end
      model_reset();
      sb.delete();
      @(negedge Clock) Reset_n = 1'b1;
      repeat (3) run_frame(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_serve();
      test_paddles();
      test_rally();
      test_game_over();
      test_reset_mid_play();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
